// File: rtl/pe_pkg.sv
// Shared definitions for the PE matrix-vector engine: data width, loader states and frame sizing.
package pe_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    KICK  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    SKIP  = 3'd4
  } loader_state_t;

  function automatic int frame_words(input int vector_size, input int matrix_size);
    return (matrix_size + 1) * vector_size;
  endfunction

endpackage

// File: rtl/pe_input_loader_if.sv
// AXI4-Stream operand channel feeding the PE input loader.
interface pe_input_loader_if
  import pe_pkg::*;
#(
  parameter int DW = DATA_W
);
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/pe_input_bram.sv
// Simple dual-port block RAM: one write port, one registered read port, no reset on contents.
module pe_input_bram #(
  parameter int DW     = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [2**ADDR_W];
  logic [DW-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pe_input_loader.sv
// Loads one operand frame from AXI4-Stream into local BRAM, kicks the engine and waits for its done window.
// Optional framing check on s_tlast is enabled by defining PE_LOADER_TLAST_CHECK_EN.
module pe_input_loader
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = 16,
  parameter int MATRIX_SIZE = 16,
  parameter int ADDR_W      = 9
) (
  input  logic               aclk,
  input  logic               areset_n,
  pe_input_loader_if.slave   s_axis,
  input  logic [31:0]        raddr,
  output logic [DATA_W-1:0]  rddata,
  output logic               start,
  input  logic               done,
  output logic               busy,
  output logic               frame_err
);

  localparam int                FW       = frame_words(VECTOR_SIZE, MATRIX_SIZE);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FW - 1);

  // Address 0 is reserved, so the frame occupies 1..FW.
  if ((2 ** ADDR_W) < (FW + 1)) begin : g_addr_chk
    $error("pe_input_loader: ADDR_W too small for frame");
  end

  loader_state_t     state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              tready_q;
  logic              start_q;
  logic              busy_q;
  logic              err_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] bram_rdata;
  logic              accept;
  logic              we;
  logic              raddr_ok;

  assign accept   = s_axis.s_tvalid && tready_q;
  assign we       = accept && (state_q == FILL);
  assign raddr_ok = (raddr != 32'd0) && (raddr <= 32'(FW));

`ifndef PE_LOADER_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis.s_tlast;
`endif

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q  <= FILL;
      wptr_q   <= '0;
      tready_q <= 1'b1;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
`ifdef PE_LOADER_TLAST_CHECK_EN
            if ((wptr_q == LAST_IDX) && s_axis.s_tlast) begin
              state_q  <= KICK;
              tready_q <= 1'b0;
              busy_q   <= 1'b1;
            end else if (wptr_q == LAST_IDX) begin
              state_q <= SKIP;
              err_q   <= 1'b1;
              wptr_q  <= '0;
            end else if (s_axis.s_tlast) begin
              err_q  <= 1'b1;
              wptr_q <= '0;
            end else begin
              wptr_q <= wptr_q + ADDR_W'(1);
            end
`else
            if (wptr_q == LAST_IDX) begin
              state_q  <= KICK;
              tready_q <= 1'b0;
              busy_q   <= 1'b1;
            end else begin
              wptr_q <= wptr_q + ADDR_W'(1);
            end
`endif
          end
        end
        KICK: begin
          start_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (done) begin
            state_q <= DRAIN;
          end
        end
        // Re-arm only once done has fallen, so start cannot overlap an old done window.
        DRAIN: begin
          if (!done) begin
            state_q  <= FILL;
            wptr_q   <= '0;
            tready_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
`ifdef PE_LOADER_TLAST_CHECK_EN
        SKIP: begin
          if (accept && s_axis.s_tlast) begin
            state_q <= FILL;
            wptr_q  <= '0;
          end
        end
`endif
        default: begin
          state_q  <= FILL;
          wptr_q   <= '0;
          tready_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range read qualifier, aligned with the BRAM read latency
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= raddr_ok;
    end
  end

  pe_input_bram #(
    .DW     (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (aclk),
    .we    (we),
    .waddr (wptr_q + ADDR_W'(1)),
    .wdata (s_axis.s_tdata),
    .raddr (raddr[ADDR_W-1:0]),
    .rdata (bram_rdata)
  );

  assign s_axis.s_tready = tready_q;
  assign start           = start_q;
  assign busy            = busy_q;
  assign frame_err       = err_q;
  assign rddata          = rvalid_q ? bram_rdata : '0;

endmodule

// File: tb/tb_pe_input_loader.sv
// Self-checking bench for pe_input_loader with a 2x2 matrix (6-word frame).
module tb_pe_input_loader;

  localparam int VS = 2;
  localparam int MS = 2;
  localparam int FW = 6;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] raddr;
  logic [31:0] rddata;
  logic        start;
  logic        done;
  logic        busy;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    bit          in_range;
  } rd_vec_t;

  rd_vec_t rd_tab [10];

  pe_input_loader_if #(.DW(32)) s_if ();

  pe_input_loader #(
    .VECTOR_SIZE (VS),
    .MATRIX_SIZE (MS),
    .ADDR_W      (4)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_axis    (s_if),
    .raddr     (raddr),
    .rddata    (rddata),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input int last_idx, input bit gaps,
                            output int acc, output int cyc, output int starts);
    logic rdy;
    acc = 0; cyc = 0; starts = 0;
    while (acc < n && cyc < 200) begin
      s_if.s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.s_tdata  = base + 32'(acc);
      s_if.s_tlast  = (acc == last_idx);
      rdy = s_if.s_tready;
      tick();
      cyc++;
      if (s_if.s_tvalid && rdy) acc++;
      if (start) starts++;
    end
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
    if (acc < n) begin
      chk("send_timeout", 32'(acc), 32'(n));
    end
  endtask

  task automatic post_frame();
    chk("kick_start", 32'(start), 32'd0);
    chk("kick_busy", 32'(busy), 32'd1);
    chk("kick_tready", 32'(s_if.s_tready), 32'd0);
    tick();
    chk("start_pulse", 32'(start), 32'd1);
    tick();
    chk("start_end", 32'(start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
  endtask

  task automatic read_check(input logic [31:0] base);
    for (int i = 0; i < 10; i++) begin
      raddr = rd_tab[i].addr;
      exp_q.push_back(rd_tab[i].in_range ? base + rd_tab[i].addr - 32'd1 : 32'd0);
      tick();
      if (exp_q.size() > 0) begin
        chk($sformatf("rddata@%0d", rd_tab[i].addr), rddata, exp_q.pop_front());
      end
    end
    raddr = 32'd0;
  endtask

  task automatic drain();
    int st;
    st = 0;
    done = 1'b1;
    repeat (6) begin
      tick();
      if (start) st++;
    end
    chk("drain_no_start", 32'(st), 32'd0);
    chk("drain_tready", 32'(s_if.s_tready), 32'd0);
    done = 1'b0;
    tick();
    chk("rearm_tready", 32'(s_if.s_tready), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_tready"}, 32'(s_if.s_tready), 32'd1);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_rddata"}, rddata, 32'd0);
  endtask

  initial begin
    int acc, cyc, st;

    for (int i = 0; i < FW; i++) begin
      rd_tab[i].addr     = 32'(i + 1);
      rd_tab[i].in_range = 1'b1;
    end
    rd_tab[6].addr = 32'd0;  rd_tab[6].in_range = 1'b0;
    rd_tab[7].addr = 32'd7;  rd_tab[7].in_range = 1'b0;
    rd_tab[8].addr = 32'd15; rd_tab[8].in_range = 1'b0;
    rd_tab[9].addr = 32'd19; rd_tab[9].in_range = 1'b0;

    areset_n      = 1'b0;
    raddr         = 32'd0;
    done          = 1'b0;
    s_if.s_tvalid = 1'b0;
    s_if.s_tdata  = 32'd0;
    s_if.s_tlast  = 1'b0;
    tick();
    tick();
    areset_n = 1'b1;
    check_reset_state("reset");

    // Frame 1: back-to-back
    send_words(32'h10, FW, FW - 1, 1'b0, acc, cyc, st);
    chk("f1_accepted", 32'(acc), 32'(FW));
    chk("f1_cycles", 32'(cyc), 32'(FW));
    chk("f1_early_start", 32'(st), 32'd0);
    post_frame();

    // Stream pushes during RUN must be refused and must not corrupt the frame
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 32'hDEAD_BEEF;
    read_check(32'h10);
    chk("run_tready", 32'(s_if.s_tready), 32'd0);
    s_if.s_tvalid = 1'b0;
    drain();

    // Frame 2 overwrites
    send_words(32'h20, FW, FW - 1, 1'b0, acc, cyc, st);
    chk("f2_cycles", 32'(cyc), 32'(FW));
    post_frame();
    read_check(32'h20);
    drain();

    // Frame 3 with random valid gaps
    send_words(32'h30, FW, FW - 1, 1'b1, acc, cyc, st);
    chk("f3_accepted", 32'(acc), 32'(FW));
    chk("f3_early_start", 32'(st), 32'd0);
    post_frame();
    read_check(32'h30);
    drain();

    // Reset in the middle of a fill
    send_words(32'h40, 3, -1, 1'b0, acc, cyc, st);
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    check_reset_state("midreset");
    send_words(32'h50, FW, FW - 1, 1'b0, acc, cyc, st);
    chk("f5_cycles", 32'(cyc), 32'(FW));
    post_frame();
    read_check(32'h50);
    drain();

`ifdef PE_LOADER_TLAST_CHECK_EN
    // Early tlast on word 3
    send_words(32'h70, 3, 2, 1'b0, acc, cyc, st);
    tick();
    tick();
    chk("early_tlast_err", 32'(frame_err), 32'd1);
    chk("early_tlast_busy", 32'(busy), 32'd0);
    chk("early_tlast_start", 32'(start), 32'd0);
    chk("early_tlast_tready", 32'(s_if.s_tready), 32'd1);

    // Missing tlast on word 6, then drop until tlast
    send_words(32'h80, FW, -1, 1'b0, acc, cyc, st);
    chk("missing_tlast_start", 32'(st), 32'd0);
    tick();
    chk("skip_tready", 32'(s_if.s_tready), 32'd1);
    chk("skip_busy", 32'(busy), 32'd0);
    chk("skip_start", 32'(start), 32'd0);
    send_words(32'h90, 2, 1, 1'b0, acc, cyc, st);
    chk("skip_drop_start", 32'(st), 32'd0);

    send_words(32'hA0, FW, FW - 1, 1'b0, acc, cyc, st);
    chk("clean_cycles", 32'(cyc), 32'(FW));
    post_frame();
    read_check(32'hA0);
    chk("err_sticky", 32'(frame_err), 32'd1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
